// File: rtl/async_fifo_pkg.sv
// Shared types and pointer-coding helpers for the async FIFO controllers.
// Used by both the write-side (full) and read-side (empty) blocks.
package async_fifo_pkg;

    // Default RAM address width; depth = 2**AFIFO_ADDRESS_BITS.
    localparam int AFIFO_ADDRESS_BITS = 9;

    typedef logic [AFIFO_ADDRESS_BITS:0]   ptr_t;
    typedef logic [AFIFO_ADDRESS_BITS-1:0] addr_t;

    // Helpers work on a 32-bit container so any pointer width up to 32 can
    // use them; callers zero-extend on the way in and truncate on the way out.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared with the read-side empty/level controller.
module gray2bin_conv
    import async_fifo_pkg::*;
#(
    parameter int W = AFIFO_ADDRESS_BITS + 1
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_o = W'(gray2bin(32'(gray_i)));
    end

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer and full-flag controller for the async FIFO (wclk only).
// Optional macro ASYNC_FIFO_WLEVEL_EN builds the fill-level and almost-full
// logic; without it wlevel and walmost_full are tied low.
module async_fifo_wptr_full
    import async_fifo_pkg::*;
#(
    parameter int ADDRESS_BITS = AFIFO_ADDRESS_BITS,
    parameter int AF_MARGIN    = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic                    winc,
    input  logic [ADDRESS_BITS:0]   wq2_read_ptr,
    output logic [ADDRESS_BITS-1:0] waddr,
    output logic                    wen,
    output logic [ADDRESS_BITS:0]   wptr,
    output logic                    wfull,
    output logic                    walmost_full,
    output logic [ADDRESS_BITS:0]   wlevel,
    output logic                    wovf
);

    localparam int PW    = ADDRESS_BITS + 1;
    localparam int DEPTH = 1 << ADDRESS_BITS;

    // Reject parameter combinations the pointer arithmetic cannot support.
    if (ADDRESS_BITS < 2) begin : g_bad_aw
        $error("async_fifo_wptr_full: ADDRESS_BITS must be >= 2");
    end
    if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("async_fifo_wptr_full: AF_MARGIN out of range 1..depth-1");
    end

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wgray_d;
    logic          wfull_q, wfull_d;
    logic          wovf_q, wovf_d;
    logic [PW-1:0] full_ptr;

    // Full when the next write pointer equals the read pointer with the two
    // MSBs inverted (one full lap ahead in Gray coding).
    assign full_ptr = {~wq2_read_ptr[ADDRESS_BITS:ADDRESS_BITS-1],
                       wq2_read_ptr[ADDRESS_BITS-2:0]};

    // Accept logic: advance on an accepted write, flag drops while full.
    always_comb begin
        wen     = winc && !wfull_q;
        wbin_d  = wbin_q + {{(PW-1){1'b0}}, wen};
        wgray_d = PW'(bin2gray(32'(wbin_d)));
        wfull_d = (wgray_d == full_ptr);
        wovf_d  = wovf_q | (winc & wfull_q);
    end

    // Pointer, full and sticky overflow registers.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wgray_d;
            wfull_q <= wfull_d;
            wovf_q  <= wovf_d;
        end
    end

    assign waddr = wbin_q[ADDRESS_BITS-1:0];
    assign wptr  = wptr_q;
    assign wfull = wfull_q;
    assign wovf  = wovf_q;

`ifdef ASYNC_FIFO_WLEVEL_EN
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] rbin;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          walmost_full_q, walmost_full_d;

    gray2bin_conv #(
        .W (PW)
    ) u_rptr_g2b (
        .gray_i (wq2_read_ptr),
        .bin_o  (rbin)
    );

    // Level against the synchronised (stale) read pointer: never underestimates.
    always_comb begin
        wlevel_d       = wbin_d - rbin;
        walmost_full_d = (wlevel_d >= AF_THRESH);
    end

    // Level and almost-full registers, refreshed every cycle.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
        end else begin
            wlevel_q       <= wlevel_d;
            walmost_full_q <= walmost_full_d;
        end
    end

    assign wlevel       = wlevel_q;
    assign walmost_full = walmost_full_q;
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule
